// File: rtl/lcd_ocimem_pkg.sv
// Shared types and constants for the Nios II OCI debug monitor memory.
package lcd_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_JRD,
    ST_CRD
  } state_e;

  // Field positions inside the 38-bit jdo word from the JTAG system-clock stage
  localparam int JDO_CLR_BIT  = 35;
  localparam int JDO_RD_BIT   = 34;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_DATA_LSB = 3;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;

  localparam int REG_STATUS  = 0;
  localparam int REG_MAILBOX = 1;

endpackage

// File: rtl/lcd_nios2_qsys_0_ocimem_ram.sv
// Single-port word RAM with byte-lane writes and a one-cycle registered read.
module lcd_nios2_qsys_0_ocimem_ram
  import lcd_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LANES-1:0]  i_be,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_nios2_qsys_0_ocimem_monitor.sv
// Nios II OCI debug monitor memory: JTAG strobes and a CPU Avalon-MM slave share one RAM, JTAG first.
// Define LCD_OCIMEM_WPROT_EN to make CPU writes below ROM_WORDS no-ops that flag monitor_error.
module lcd_nios2_qsys_0_ocimem_monitor
  import lcd_ocimem_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int ROM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W:0]   address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              waitrequest
);

`ifdef LCD_OCIMEM_WPROT_EN
  localparam bit c_WPROT_EN = 1'b1;
`else
  localparam bit c_WPROT_EN = 1'b0;
`endif

  state_e            r_state, w_nextState;
  logic [ADDR_W-1:0] r_monAReg;
  logic [31:0]       r_monDReg, r_readdata;
  logic              r_jrdPend, r_jwrPend, r_ready, r_error, r_regAck, r_wprotHit;

  logic [ADDR_W-1:0] w_ramAddr, w_cpuAddr;
  logic [3:0]        w_ramBe;
  logic [31:0]       w_ramWdata, w_ramRdata, w_regRdata;
  logic              w_busy, w_takeA, w_takeNoA, w_takeB, w_jtagClr;
  logic              w_regSel, w_cpuGrant, w_cpuRamRd, w_cpuRamWr, w_cpuRegRd, w_cpuRegWr;
  logic              w_wprotBlock, w_wait, w_unusedJdo;

  // A strobe is dropped whole while any JTAG operation is still pending or in service
  assign w_busy    = r_jrdPend | r_jwrPend | (r_state == ST_JRD);
  assign w_takeA   = take_action_ocimem_a & ~w_busy;
  assign w_takeNoA = take_no_action_ocimem_a & ~take_action_ocimem_a & ~w_busy;
  assign w_takeB   = take_action_ocimem_b & ~take_action_ocimem_a & ~take_no_action_ocimem_a & ~w_busy;
  assign w_jtagClr = w_takeA & jdo[JDO_CLR_BIT];

  assign w_regSel     = address[ADDR_W];
  assign w_cpuAddr    = address[ADDR_W-1:0];
  assign w_cpuGrant   = (r_state == ST_IDLE) & ~r_jwrPend & ~r_jrdPend;
  assign w_cpuRamRd   = read & ~w_regSel;
  assign w_cpuRamWr   = write & ~read & ~w_regSel;
  assign w_cpuRegRd   = read & w_regSel;
  assign w_cpuRegWr   = write & ~read & w_regSel;
  assign w_wprotBlock = c_WPROT_EN & (32'(w_cpuAddr) < ROM_WORDS);
  assign w_unusedJdo  = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    w_regRdata = '0;
    if (32'(w_cpuAddr) == REG_STATUS)       w_regRdata = {30'b0, r_error, r_ready};
    else if (32'(w_cpuAddr) == REG_MAILBOX) w_regRdata = r_monDReg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (r_jwrPend)       w_nextState = ST_IDLE;
        else if (r_jrdPend)  w_nextState = ST_JRD;
        else if (w_cpuRamRd) w_nextState = ST_CRD;
      end
      ST_JRD:  w_nextState = ST_IDLE;
      ST_CRD:  w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ramAddr  = r_monAReg;
    w_ramBe    = 4'h0;
    w_ramWdata = r_monDReg;
    w_wait     = 1'b0;
    if (r_state == ST_IDLE) begin
      if (r_jwrPend) begin
        w_ramBe = 4'hF;
      end else if (!r_jrdPend) begin
        if (w_cpuRamRd) begin
          w_ramAddr = w_cpuAddr;
        end else if (w_cpuRamWr) begin
          w_ramAddr  = w_cpuAddr;
          w_ramWdata = writedata;
          w_ramBe    = w_wprotBlock ? 4'h0 : byteenable;
        end
      end
    end
    if (w_cpuRamRd)      w_wait = (r_state != ST_CRD);
    else if (w_cpuRegRd) w_wait = ~r_regAck;
    else if (w_cpuRamWr) w_wait = ~w_cpuGrant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_monAReg  <= '0;
      r_monDReg  <= '0;
      r_jrdPend  <= 1'b0;
      r_jwrPend  <= 1'b0;
      r_ready    <= 1'b0;
      r_error    <= 1'b0;
      r_readdata <= '0;
      r_regAck   <= 1'b0;
      r_wprotHit <= 1'b0;
    end else begin
      r_regAck   <= w_cpuRegRd & ~r_regAck;
      r_wprotHit <= w_cpuRamWr & w_cpuGrant & w_wprotBlock;
      if (w_cpuRegRd && !r_regAck) r_readdata <= w_regRdata;
      else if (r_state == ST_CRD)  r_readdata <= w_ramRdata;

      if (w_takeA) begin
        r_monAReg <= jdo[JDO_ADDR_LSB +: ADDR_W];
        if (jdo[JDO_RD_BIT]) r_jrdPend <= 1'b1;
      end else if (w_takeNoA) begin
        r_jrdPend <= 1'b1;
      end else if (w_takeB) begin
        r_monDReg <= jdo[JDO_DATA_LSB +: 32];
        r_jwrPend <= 1'b1;
      end

      if (r_state == ST_IDLE && r_jwrPend) begin
        r_monAReg <= r_monAReg + 1'b1;
        r_jwrPend <= 1'b0;
      end
      if (r_state == ST_JRD) begin
        r_monDReg <= w_ramRdata;
        r_monAReg <= r_monAReg + 1'b1;
        r_jrdPend <= 1'b0;
      end

      // A JTAG clear overrides any status set landing in the same cycle
      if (w_jtagClr) begin
        r_ready <= 1'b0;
        r_error <= 1'b0;
      end else begin
        if (w_cpuRegWr && 32'(w_cpuAddr) == REG_STATUS) begin
          if (writedata[0]) r_ready <= 1'b1;
          if (writedata[1]) r_error <= 1'b1;
        end
        if (r_wprotHit) r_error <= 1'b1;
      end
    end
  end

  lcd_nios2_qsys_0_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (clk),
    .i_addr  (w_ramAddr),
    .i_be    (w_ramBe),
    .i_wdata (w_ramWdata),
    .o_rdata (w_ramRdata)
  );

  assign MonDReg       = r_monDReg;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;
  assign readdata      = (r_state == ST_CRD) ? w_ramRdata : r_readdata;
  assign waitrequest   = w_wait;

endmodule

// File: tb/tb_lcd_nios2_qsys_0_ocimem_monitor.sv
// Randomized bench for the OCI monitor memory; a transaction-level model predicts every visible output.
// Honours LCD_OCIMEM_WPROT_EN so the same bench covers both builds.
module tb_lcd_nios2_qsys_0_ocimem_monitor;

  localparam int ADDR_W    = 8;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int ROM_WORDS = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error;
  logic [ADDR_W:0]   address;
  logic              read, write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              waitrequest;

  // Model state: RAM image, JTAG address/data registers and status bits
  logic [31:0]       mMem [DEPTH];
  logic [ADDR_W-1:0] mAddr;
  logic [31:0]       mMonD;
  logic              mReady, mError;
  logic              cmpEn;
  int                checks = 0;
  int                passes = 0;

  lcd_nios2_qsys_0_ocimem_monitor #(.ADDR_W(ADDR_W), .ROM_WORDS(ROM_WORDS)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .readdata                (readdata),
    .waitrequest             (waitrequest)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Every cycle: JTAG data register and status bits track the model; an idle bus never stalls
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("MonDReg", MonDReg, mMonD);
      checkOutput("monitor_ready", 32'(monitor_ready), 32'(mReady));
      checkOutput("monitor_error", 32'(monitor_error), 32'(mError));
      if (!read && !write) checkOutput("waitrequest_idle", 32'(waitrequest), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    mAddr = '0; mMonD = '0; mReady = 1'b0; mError = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
  endtask

  function automatic logic [37:0] jdoA(input logic clr, input logic rd, input logic [ADDR_W-1:0] a);
    logic [37:0] j;
    j = 38'({$urandom, $urandom});
    j[35] = clr;
    j[34] = rd;
    j[17 +: ADDR_W] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdoB(input logic [31:0] d);
    logic [37:0] j;
    j = 38'({$urandom, $urandom});
    j[3 +: 32] = d;
    return j;
  endfunction

  task automatic strobe(input logic a, input logic na, input logic b, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b = b;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask

  // Read completes two cycles after the strobe cycle; a junk strobe in between must be ignored
  task automatic jtagReadTail(input logic drop);
    if (drop) begin
      logic [37:0] j;
      j = 38'({$urandom, $urandom});
      case ($urandom_range(0, 2))
        0:       strobe(1'b1, 1'b0, 1'b0, j);
        1:       strobe(1'b0, 1'b1, 1'b0, j);
        default: strobe(1'b0, 1'b0, 1'b1, j);
      endcase
    end else begin
      idleCycle();
    end
    idleCycle();
    mMonD = mMem[mAddr];
    mAddr = mAddr + 1'b1;
  endtask

  task automatic jtagLoad(input logic [ADDR_W-1:0] a, input logic clr, input logic rd,
                          input logic drop, input logic all3);
    strobe(1'b1, all3, all3, jdoA(clr, rd, a));
    mAddr = a;
    if (clr) begin mReady = 1'b0; mError = 1'b0; end
    if (rd) jtagReadTail(drop);
  endtask

  task automatic jtagNoAction(input logic drop, input logic withB);
    strobe(1'b0, 1'b1, withB, 38'({$urandom, $urandom}));
    jtagReadTail(drop);
  endtask

  task automatic jtagWrite(input logic [31:0] d);
    strobe(1'b0, 1'b0, 1'b1, jdoB(d));
    mMonD = d;
    idleCycle();
    mMem[mAddr] = d;
    mAddr = mAddr + 1'b1;
  endtask

  task automatic cpuWrite(input logic [ADDR_W:0] a, input logic [31:0] d, input logic [3:0] be);
    logic prot;
    prot = 1'b0;
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(negedge clk);
    checkOutput("cpu_wr_wait", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    write = 1'b0;
    if (!a[ADDR_W]) begin
`ifdef LCD_OCIMEM_WPROT_EN
      prot = (int'(a[ADDR_W-1:0]) < ROM_WORDS);
`endif
      if (!prot)
        for (int b = 0; b < 4; b++)
          if (be[b]) mMem[a[ADDR_W-1:0]][8*b +: 8] = d[8*b +: 8];
    end else if (a[ADDR_W-1:0] == '0) begin
      if (d[0]) mReady = 1'b1;
      if (d[1]) mError = 1'b1;
    end
    if (prot) begin
      idleCycle();
      mError = 1'b1;
    end
  endtask

  task automatic cpuRead(input logic [ADDR_W:0] a, input int expLat, input logic [31:0] expData,
                         input string name);
    int n;
    n = 0;
    address = a; read = 1'b1;
    @(negedge clk);
    while (waitrequest && n < 8) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_latency"}, 32'(n), 32'(expLat));
    checkOutput(name, readdata, expData);
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic applyStimulus(input int op);
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    int                off;
    a = ADDR_W'($urandom);
    d = $urandom;
    case (op)
      0: jtagLoad(a, ($urandom_range(0, 3) == 0), 1'b1, 1'($urandom), 1'b0);
      1: jtagLoad(a, 1'($urandom), 1'b0, 1'b0, 1'($urandom));
      2: jtagNoAction(1'($urandom), 1'b0);
      3: jtagWrite(d);
      4: cpuRead({1'b0, a}, 1, mMem[a], "cpu_ram_read");
      5: cpuWrite({1'b0, a}, d, 4'($urandom));
      6: cpuWrite({1'b1, ADDR_W'(0)}, d, 4'hF);
      7: begin
        off = $urandom_range(0, 3);
        if (off == 0)      cpuRead({1'b1, ADDR_W'(0)}, 1, {30'b0, mError, mReady}, "status_read");
        else if (off == 1) cpuRead({1'b1, ADDR_W'(1)}, 1, mMonD, "mailbox_read");
        else cpuRead({1'b1, ADDR_W'($urandom_range(2, DEPTH - 1))}, 1, 32'd0, "reserved_read");
      end
      8: cpuWrite({1'b1, ADDR_W'($urandom_range(1, DEPTH - 1))}, d, 4'hF);
      default: begin
        if ($urandom_range(0, 1) == 1) jtagLoad(a, 1'($urandom), 1'b1, 1'b0, 1'b1);
        else jtagNoAction(1'b0, 1'b1);
      end
    endcase
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;
    cmpEn = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_MonDReg", MonDReg, 32'd0);
    checkOutput("reset_ready", 32'(monitor_ready), 32'd0);
    checkOutput("reset_error", 32'(monitor_error), 32'd0);
    checkOutput("reset_readdata", readdata, 32'd0);
    checkOutput("reset_waitrequest", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cmpEn = 1'b1;

    // Fill the whole RAM through JTAG so the model knows every word
    jtagLoad('0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) jtagWrite($urandom);

    // Address load + read, then auto-increment read
    jtagLoad(8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    jtagWrite(32'hDEAD_BEEF);
    jtagWrite(32'hCAFE_F00D);
    jtagLoad(8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("load_and_read", MonDReg, 32'hDEAD_BEEF);
    jtagNoAction(1'b0, 1'b0);
    checkOutput("read_after_increment", MonDReg, 32'hCAFE_F00D);

    // Auto-increment writes across the top of the address space
    jtagLoad(8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    jtagWrite(32'd1);
    jtagWrite(32'd2);
    jtagWrite(32'd3);
    cpuRead(9'h0FE, 1, 32'd1, "wrap_fe");
    cpuRead(9'h0FF, 1, 32'd2, "wrap_ff");
    cpuRead(9'h000, 1, 32'd3, "wrap_00");

    // CPU read stalled behind a pending JTAG write to the same word
    jtagLoad(8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, jdoB(32'h1234_5678));
    mMonD = 32'h1234_5678;
    mMem[8'h20] = 32'h1234_5678;
    mAddr = 8'h21;
    cpuRead(9'h020, 2, 32'h1234_5678, "collision_read");

    // Status handshake, then a JTAG clear racing a CPU status set
    cpuWrite(9'h100, 32'h1, 4'hF);
    checkOutput("status_ready_set", 32'(monitor_ready), 32'd1);
    address = 9'h100; writedata = 32'h3; byteenable = 4'hF; write = 1'b1;
    strobe(1'b1, 1'b0, 1'b0, jdoA(1'b1, 1'b0, 8'h40));
    write = 1'b0;
    mAddr = 8'h40; mReady = 1'b0; mError = 1'b0;
    checkOutput("clear_wins_ready", 32'(monitor_ready), 32'd0);
    checkOutput("clear_wins_error", 32'(monitor_error), 32'd0);
    cpuRead(9'h100, 1, 32'd0, "status_after_clear");

`ifdef LCD_OCIMEM_WPROT_EN
    jtagLoad(8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    jtagWrite(32'hA5A5_A5A5);
    cpuWrite(9'h005, 32'h55, 4'hF);
    checkOutput("wprot_error", 32'(monitor_error), 32'd1);
    cpuRead(9'h005, 1, 32'hA5A5_A5A5, "wprot_ram_kept");
    jtagLoad(8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    jtagWrite(32'h55);
    cpuRead(9'h005, 1, 32'h55, "wprot_jtag_write");
`else
    cpuWrite(9'h005, 32'h55, 4'hF);
    cpuRead(9'h005, 1, 32'h55, "cpu_write_lands");
    checkOutput("no_wprot_error", 32'(monitor_error), 32'd0);
`endif

    // Reset while a JTAG read sits in its data phase
    strobe(1'b1, 1'b0, 1'b0, jdoA(1'b0, 1'b1, 8'h30));
    idleCycle();
    reset_n = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("midreset_MonDReg", MonDReg, 32'd0);
    checkOutput("midreset_readdata", readdata, 32'd0);
    checkOutput("midreset_waitrequest", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    jtagNoAction(1'b0, 1'b0);
    checkOutput("post_reset_read_addr0", MonDReg, 32'd3);

    for (int i = 0; i < 300; i++) applyStimulus($urandom_range(0, 9));

    idleCycle();
    cmpEn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
